// File: rtl/wbs_slave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wbs_slave_ctrl
//  Brief    : Wishbone classic slave for the kd-tree core: CSRs, SRAM windows.
//  Revision : 1.0
// ============================================================================
module wbs_slave_ctrl #(
    parameter logic [31:0] REG_BASE   = 32'h3000_0000,
    parameter logic [31:0] QUERY_BASE = 32'h3001_0000,
    parameter logic [31:0] LEAF_BASE  = 32'h3002_0000,
    parameter logic [31:0] BEST_BASE  = 32'h3003_0000,
    parameter logic [31:0] NODE_BASE  = 32'h3004_0000,
    parameter logic [31:0] ADDR_MASK  = 32'hFFFF_0000,
    parameter int          QADDR_W    = 12,
    parameter int          LADDR_W    = 12,
    parameter int          BADDR_W    = 9,
    parameter int          NADDR_W    = 6
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               mode_o,
    output logic               debug_o,
    output logic               fsm_start_o,
    input  logic               fsm_done_i,
    input  logic               fsm_busy_i,
    output logic               node_we_o,
    output logic [NADDR_W-1:0] node_addr_o,
    output logic [21:0]        node_wdata_o,
    output logic               leaf_we_o,
    output logic [LADDR_W-1:0] leaf_addr_o,
    output logic [63:0]        leaf_wdata_o,
    output logic               query_we_o,
    output logic [QADDR_W-1:0] query_addr_o,
    output logic [54:0]        query_wdata_o,
    output logic               best_re_o,
    output logic [BADDR_W-1:0] best_addr_o,
    input  logic [63:0]        best_rdata_i
);

    localparam logic [31:0] C_OFF_MODE  = 32'h0000_0000;
    localparam logic [31:0] C_OFF_DEBUG = 32'h0000_0004;
    localparam logic [31:0] C_OFF_DONE  = 32'h0000_0008;
    localparam logic [31:0] C_OFF_START = 32'h0000_000C;
    localparam logic [31:0] C_OFF_BUSY  = 32'h0000_0010;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACK     = 2'd1,
        S_RD_WAIT = 2'd2,
        S_RD_CAP  = 2'd3
    } state_t;

    state_t               state_q;
    logic                 ack_q;
    logic [31:0]          reg_dat_q;
    logic                 rd_best_q;
    logic                 rd_half_q;
    logic [63:0]          rd_hold_q;
    logic [31:0]          hold_lo_q;
    logic                 mode_q;
    logic                 debug_q;
    logic                 done_q;
    logic                 start_q;
    logic                 node_we_q;
    logic [NADDR_W-1:0]   node_addr_q;
    logic [21:0]          node_wdata_q;
    logic                 leaf_we_q;
    logic [LADDR_W-1:0]   leaf_addr_q;
    logic [63:0]          leaf_wdata_q;
    logic                 query_we_q;
    logic [QADDR_W-1:0]   query_addr_q;
    logic [54:0]          query_wdata_q;
    logic                 best_re_q;
    logic [BADDR_W-1:0]   best_addr_q;

    logic        w_req;
    logic [31:0] w_off;
    logic        w_half;
    logic        w_hit_reg;
    logic        w_hit_query;
    logic        w_hit_leaf;
    logic        w_hit_best;
    logic        w_hit_node;
    logic [31:0] w_reg_rdata;
    logic        w_unused_sel;

    assign w_req       = wbs_cyc_i & wbs_stb_i;
    assign w_off       = wbs_adr_i & ~ADDR_MASK;
    assign w_half      = w_off[2];
    assign w_hit_reg   = (wbs_adr_i & ADDR_MASK) == REG_BASE;
    assign w_hit_query = (wbs_adr_i & ADDR_MASK) == QUERY_BASE;
    assign w_hit_leaf  = (wbs_adr_i & ADDR_MASK) == LEAF_BASE;
    assign w_hit_best  = (wbs_adr_i & ADDR_MASK) == BEST_BASE;
    assign w_hit_node  = (wbs_adr_i & ADDR_MASK) == NODE_BASE;
    assign w_unused_sel = &{1'b0, wbs_sel_i};

    always_comb begin
        w_reg_rdata = 32'h0;
        case (w_off)
            C_OFF_MODE:  w_reg_rdata = {31'h0, mode_q};
            C_OFF_DEBUG: w_reg_rdata = {31'h0, debug_q};
            C_OFF_DONE:  w_reg_rdata = {31'h0, done_q};
            C_OFF_BUSY:  w_reg_rdata = {31'h0, fsm_busy_i};
            default:     w_reg_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= S_IDLE;
            ack_q         <= 1'b0;
            reg_dat_q     <= 32'h0;
            rd_best_q     <= 1'b0;
            rd_half_q     <= 1'b0;
            rd_hold_q     <= 64'h0;
            hold_lo_q     <= 32'h0;
            mode_q        <= 1'b0;
            debug_q       <= 1'b0;
            done_q        <= 1'b0;
            start_q       <= 1'b0;
            node_we_q     <= 1'b0;
            node_addr_q   <= '0;
            node_wdata_q  <= 22'h0;
            leaf_we_q     <= 1'b0;
            leaf_addr_q   <= '0;
            leaf_wdata_q  <= 64'h0;
            query_we_q    <= 1'b0;
            query_addr_q  <= '0;
            query_wdata_q <= 55'h0;
            best_re_q     <= 1'b0;
            best_addr_q   <= '0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            start_q    <= 1'b0;
            node_we_q  <= 1'b0;
            leaf_we_q  <= 1'b0;
            query_we_q <= 1'b0;
            best_re_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (w_req) begin
                        state_q   <= S_ACK;
                        ack_q     <= 1'b1;
                        reg_dat_q <= 32'h0;
                        rd_best_q <= 1'b0;
                        if (wbs_we_i) begin
                            if (w_hit_reg) begin
                                case (w_off)
                                    C_OFF_MODE:  mode_q  <= wbs_dat_i[0];
                                    C_OFF_DEBUG: debug_q <= wbs_dat_i[0];
                                    C_OFF_START: begin
                                        start_q <= 1'b1;
                                        done_q  <= 1'b0;
                                    end
                                    default: ;
                                endcase
                            end else if (w_hit_node) begin
                                node_we_q    <= 1'b1;
                                node_addr_q  <= w_off[2 +: NADDR_W];
                                node_wdata_q <= wbs_dat_i[21:0];
                            end else if (w_hit_leaf) begin
                                if (w_half) begin
                                    leaf_we_q    <= 1'b1;
                                    leaf_addr_q  <= w_off[3 +: LADDR_W];
                                    leaf_wdata_q <= {wbs_dat_i, hold_lo_q};
                                end else begin
                                    hold_lo_q <= wbs_dat_i;
                                end
                            end else if (w_hit_query) begin
                                if (w_half) begin
                                    query_we_q    <= 1'b1;
                                    query_addr_q  <= w_off[3 +: QADDR_W];
                                    query_wdata_q <= {wbs_dat_i[22:0], hold_lo_q};
                                end else begin
                                    hold_lo_q <= wbs_dat_i;
                                end
                            end
                        end else if (w_hit_best) begin
                            // Best entries need an SRAM round trip before the ack.
                            state_q     <= S_RD_WAIT;
                            ack_q       <= 1'b0;
                            best_re_q   <= 1'b1;
                            best_addr_q <= w_off[3 +: BADDR_W];
                            rd_half_q   <= w_half;
                            rd_best_q   <= 1'b1;
                        end else if (w_hit_reg) begin
                            reg_dat_q <= w_reg_rdata;
                        end
                    end
                end
                S_RD_WAIT: state_q <= S_RD_CAP;
                S_RD_CAP: begin
                    rd_hold_q <= best_rdata_i;
                    ack_q     <= 1'b1;
                    state_q   <= S_ACK;
                end
                S_ACK: begin
                    ack_q     <= 1'b0;
                    reg_dat_q <= 32'h0;
                    rd_best_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (fsm_done_i) begin
                done_q <= 1'b1;
            end
        end
    end

    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = !ack_q   ? 32'h0 :
                           rd_best_q ? (rd_half_q ? rd_hold_q[63:32] : rd_hold_q[31:0]) :
                                       reg_dat_q;
    assign mode_o        = mode_q;
    assign debug_o       = debug_q;
    assign fsm_start_o   = start_q;
    assign node_we_o     = node_we_q;
    assign node_addr_o   = node_addr_q;
    assign node_wdata_o  = node_wdata_q;
    assign leaf_we_o     = leaf_we_q;
    assign leaf_addr_o   = leaf_addr_q;
    assign leaf_wdata_o  = leaf_wdata_q;
    assign query_we_o    = query_we_q;
    assign query_addr_o  = query_addr_q;
    assign query_wdata_o = query_wdata_q;
    assign best_re_o     = best_re_q;
    assign best_addr_o   = best_addr_q;

endmodule
`default_nettype wire
